// File: rtl/axis_audio_pkg.sv
// Shared types and helpers for the AXIS audio gain path.
package axis_audio_pkg;

  // Frame sequencing states of the gain stage.
  typedef enum logic [1:0] {
    ST_RECV = 2'd0,
    ST_MULT = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Gains are unsigned Q1.F with F equal to the switch width. The helper
  // below works on the widest supported F; callers pass their actual F.
  localparam int GAIN_FRAC_MAX = 16;

  typedef logic [GAIN_FRAC_MAX:0] gain_t;

  // Map switch/mute to a target gain: mute -> 0, all-ones -> exact unity.
  function automatic gain_t target_gain(input logic [GAIN_FRAC_MAX-1:0] sw,
                                        input logic mute,
                                        input int frac);
    gain_t unity;
    gain_t ones;
    gain_t tgt;
    unity = gain_t'(1) << frac;
    ones  = unity - gain_t'(1);
    if (mute) begin
      tgt = '0;
    end else if ({1'b0, sw} == ones) begin
      tgt = unity;
    end else begin
      tgt = {1'b0, sw};
    end
    return tgt;
  endfunction

endpackage

// File: rtl/axis_multichannel_gain_gain_slew.sv
// Current-gain register that slews toward the switch target one step per update.
module gain_slew
  import axis_audio_pkg::*;
#(
  parameter int GAIN_WIDTH = 4,
  parameter int RAMP_STEP  = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  update,
  input  logic [GAIN_WIDTH-1:0] sw,
  input  logic                  mute,
  output logic [GAIN_WIDTH:0]   gain_cur
);

  localparam logic [GAIN_WIDTH:0] STEP = (GAIN_WIDTH + 1)'(RAMP_STEP);

  logic [GAIN_WIDTH:0] gain_q, gain_d;
  logic [GAIN_WIDTH:0] tgt;
  logic [GAIN_WIDTH:0] diff;

  // Move toward the target by STEP on update, landing exactly on it when close.
  always_comb begin
    tgt    = (GAIN_WIDTH + 1)'(target_gain(GAIN_FRAC_MAX'(sw), mute, GAIN_WIDTH));
    gain_d = gain_q;
    diff   = '0;
    if (update) begin
      if (gain_q < tgt) begin
        diff   = tgt - gain_q;
        gain_d = (diff <= STEP) ? tgt : gain_q + STEP;
      end else if (gain_q > tgt) begin
        diff   = gain_q - tgt;
        gain_d = (diff <= STEP) ? tgt : gain_q - STEP;
      end
    end
  end

  // Gain register; restarts from silence after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gain_q <= '0;
    end else begin
      gain_q <= gain_d;
    end
  end

  assign gain_cur = gain_q;

endmodule

// File: rtl/axis_multichannel_gain.sv
// AXIS N-channel gain stage: receive a frame, scale each channel through one
// shared multiplier, then send the frame. No overlap between receive and send.
//
// state   | meaning
// RECV    | accepting words into channel slots 0..N-1
// MULT    | scaling channel k in cycle k, in place
// SEND    | presenting channels 0..N-1, last on N-1
module axis_multichannel_gain
  import axis_audio_pkg::*;
#(
  parameter int DATA_WIDTH   = 24,
  parameter int NUM_CHANNELS = 2,
  parameter int GAIN_WIDTH   = 4,
  parameter int RAMP_STEP    = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [GAIN_WIDTH-1:0] sw,
  input  logic                  mute,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic                  s_axis_last,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic [GAIN_WIDTH:0]   gain_cur,
  output logic                  frame_err
);

  localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        idx_nxt;
  logic [DATA_WIDTH-1:0]   smp_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   smp_d [NUM_CHANNELS];
  logic                    s_ready_q, s_ready_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                    err_q, err_d;
  logic                    update;
  logic [GAIN_WIDTH:0]     gain_w;

  logic signed [PROD_W-1:0] mul_a, mul_b, mul_p;
  logic [DATA_WIDTH-1:0]    mul_res;

  gain_slew #(
    .GAIN_WIDTH (GAIN_WIDTH),
    .RAMP_STEP  (RAMP_STEP)
  ) u_gain_slew (
    .clk      (clk),
    .resetn   (resetn),
    .update   (update),
    .sw       (sw),
    .mute     (mute),
    .gain_cur (gain_w)
  );

  // Shared multiplier: sample sign-extended, gain zero-extended, floor shift.
  always_comb begin
    mul_a   = {{(GAIN_WIDTH + 1){smp_q[idx_q][DATA_WIDTH-1]}}, smp_q[idx_q]};
    mul_b   = {{DATA_WIDTH{1'b0}}, gain_w};
    mul_p   = mul_a * mul_b;
    mul_res = DATA_WIDTH'(mul_p >>> GAIN_WIDTH);
  end

  // Next-state and datapath decisions for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    smp_d     = smp_q;
    s_ready_d = s_ready_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    err_d     = 1'b0;
    update    = 1'b0;
    idx_nxt   = idx_q + IDX_W'(1);
    case (state_q)
      ST_RECV: begin
        if (s_axis_valid && s_ready_q) begin
          smp_d[idx_q] = s_axis_data;
          if (s_axis_last || (idx_q == LAST_IDX)) begin
            // Early last and missing last both close the frame but are flagged.
            err_d = s_axis_last ^ (idx_q == LAST_IDX);
            for (int k = 0; k < NUM_CHANNELS; k++) begin
              if (k > int'(idx_q)) smp_d[k] = '0;
            end
            idx_d     = '0;
            state_d   = ST_MULT;
            s_ready_d = 1'b0;
            update    = 1'b1;
          end else begin
            idx_d = idx_nxt;
          end
        end
      end
      ST_MULT: begin
        smp_d[idx_q] = mul_res;
        if (idx_q == LAST_IDX) begin
          idx_d     = '0;
          state_d   = ST_SEND;
          m_valid_d = 1'b1;
          m_last_d  = (NUM_CHANNELS == 1);
          // Channel 0 is already scaled unless it is the one finishing now.
          m_data_d  = (NUM_CHANNELS == 1) ? mul_res : smp_q[0];
        end else begin
          idx_d = idx_nxt;
        end
      end
      ST_SEND: begin
        if (m_axis_ready) begin
          if (m_last_q) begin
            idx_d     = '0;
            state_d   = ST_RECV;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            s_ready_d = 1'b1;
          end else begin
            idx_d    = idx_nxt;
            m_data_d = smp_q[idx_nxt];
            m_last_d = (idx_nxt == LAST_IDX);
          end
        end
      end
      default: begin
        state_d = ST_RECV;
      end
    endcase
  end

  // Sequencer registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_RECV;
      idx_q     <= '0;
      for (int k = 0; k < NUM_CHANNELS; k++) smp_q[k] <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      smp_q     <= smp_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      err_q     <= err_d;
    end
  end

  assign s_axis_ready = s_ready_q;
  assign m_axis_valid = m_valid_q;
  assign m_axis_last  = m_last_q;
  assign m_axis_data  = m_data_q;
  assign frame_err    = err_q;
  assign gain_cur     = gain_w;

endmodule

// File: tb/tb_axis_multichannel_gain.sv
// Scoreboard bench for axis_multichannel_gain (DW=24, N=2, GW=4, step 1).
module tb_axis_multichannel_gain;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  sw;
  logic        mute;
  logic [23:0] s_axis_data;
  logic        s_axis_valid;
  logic        s_axis_ready;
  logic        s_axis_last;
  logic [23:0] m_axis_data;
  logic        m_axis_valid;
  logic        m_axis_ready;
  logic        m_axis_last;
  logic [4:0]  gain_cur;
  logic        frame_err;

  axis_multichannel_gain #(
    .DATA_WIDTH   (24),
    .NUM_CHANNELS (2),
    .GAIN_WIDTH   (4),
    .RAMP_STEP    (1)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .sw           (sw),
    .mute         (mute),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .s_axis_last  (s_axis_last),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
    .m_axis_last  (m_axis_last),
    .gain_cur     (gain_cur),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;
    logic        l;
    logic [4:0]  g;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   err_pulses = 0;
  int   gexp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] scale(input logic [23:0] x, input int g);
    longint p;
    p = longint'($signed(x)) * longint'(g);
    return 24'(p >>> 4);
  endfunction

  // Reference gain slew applied once per frame.
  task automatic step_gain();
    int tgt;
    tgt = mute ? 0 : ((sw == 4'hF) ? 16 : int'(sw));
    if (gexp < tgt) gexp++;
    else if (gexp > tgt) gexp--;
  endtask

  task automatic push(input logic [23:0] d, input logic l);
    exp_t e;
    e.d = d; e.l = l; e.g = 5'(gexp);
    exp_q.push_back(e);
  endtask

  task automatic send_word(input logic [23:0] d, input logic l);
    int n;
    @(posedge clk); #1;
    s_axis_valid = 1'b1; s_axis_data = d; s_axis_last = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_axis_ready) break;
      n++;
      if (n > 500) begin
        errors++; checks++;
        $display("FAIL send_timeout: ready 0 expected 1 at %0t", $time);
        break;
      end
    end
    @(posedge clk); #1;
    s_axis_valid = 1'b0; s_axis_last = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_axis_valid) break;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic frame2(input logic [23:0] w0, input logic [23:0] w1,
                        input logic [23:0] e0, input logic [23:0] e1);
    step_gain();
    push(e0, 1'b0);
    push(e1, 1'b1);
    send_word(w0, 1'b0);
    send_word(w1, 1'b1);
    wait_drain();
  endtask

  // Output monitor: compare each handshaken word against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && m_axis_valid && m_axis_ready) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_output: data 0x%0h with empty queue", m_axis_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_axis_data, e.d);
          chk("out_last", m_axis_last, e.l);
          chk("out_gain", gain_cur, e.g);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (frame_err) err_pulses++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int e0;
    resetn = 1'b0; sw = 4'hF; mute = 1'b0;
    s_axis_data = '0; s_axis_valid = 1'b0; s_axis_last = 1'b0; m_axis_ready = 1'b1;
    #22;
    chk("rst_s_ready", s_axis_ready, 1);
    chk("rst_m_valid", m_axis_valid, 0);
    chk("rst_m_last", m_axis_last, 0);
    chk("rst_m_data", m_axis_data, 0);
    chk("rst_gain", gain_cur, 0);
    chk("rst_frame_err", frame_err, 0);
    @(negedge clk); resetn = 1'b1;

    // Ramp up from reset, with latency measurement.
    step_gain();
    push(24'h010000, 1'b0);
    push(24'hFF0000, 1'b1);
    send_word(24'h100000, 1'b0);
    send_word(24'hF00000, 1'b1);
    chk("closed_s_ready", s_axis_ready, 0);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (m_axis_valid) break;
    end
    chk("latency", lat, 2);
    wait_drain();
    chk("frame_err_clean", err_pulses, 0);

    // Ramp to unity, then pass full-scale samples unchanged.
    for (int f = 2; f <= 16; f++)
      frame2(24'h100000, 24'hF00000, scale(24'h100000, gexp + 1), scale(24'hF00000, gexp + 1));
    chk("unity_gain", gain_cur, 16);
    frame2(24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000);

    // Mute ramps down to silence over 16 frames.
    mute = 1'b1;
    for (int f = 1; f <= 15; f++)
      frame2(24'h100000, 24'h7FFFFF, scale(24'h100000, gexp - 1), scale(24'h7FFFFF, gexp - 1));
    frame2(24'h100000, 24'h7FFFFF, 24'h000000, 24'h000000);
    chk("muted_gain", gain_cur, 0);
    mute = 1'b0;
    frame2(24'h100000, 24'hFFFFFF, 24'h010000, 24'hFFFFFF);
    chk("unmute_gain1", gain_cur, 1);
    frame2(24'h100000, 24'h000010, 24'h020000, 24'h000002);
    chk("unmute_gain2", gain_cur, 2);
    for (int f = 3; f <= 16; f++)
      frame2(24'h123456, 24'hFEDCBA, scale(24'h123456, gexp + 1), scale(24'hFEDCBA, gexp + 1));
    chk("regain_unity", gain_cur, 16);

    // Early last: one word closes the frame, second channel zero-filled.
    e0 = err_pulses;
    step_gain();
    push(24'h200000, 1'b0);
    push(24'h000000, 1'b1);
    send_word(24'h200000, 1'b1);
    wait_drain();
    chk("early_last_err", err_pulses - e0, 1);

    // Missing last: Nth word closes the frame; next word starts a new one.
    e0 = err_pulses;
    step_gain();
    push(24'h0ABCDE, 1'b0);
    push(24'h654321, 1'b1);
    send_word(24'h0ABCDE, 1'b0);
    send_word(24'h654321, 1'b0);
    wait_drain();
    chk("missing_last_err", err_pulses - e0, 1);
    frame2(24'h000001, 24'h000002, 24'h000001, 24'h000002);
    chk("resync_no_err", err_pulses - e0, 1);

    // Backpressure: output held, input stalled while a word is offered.
    m_axis_ready = 1'b0;
    step_gain();
    push(24'h123456, 1'b0);
    push(24'h654321, 1'b1);
    send_word(24'h123456, 1'b0);
    send_word(24'h654321, 1'b1);
    s_axis_valid = 1'b1; s_axis_data = 24'hABCDEF; s_axis_last = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_axis_valid) break;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", m_axis_valid, 1);
      chk("bp_data", m_axis_data, 24'h123456);
      chk("bp_last", m_axis_last, 0);
      chk("bp_s_ready", s_axis_ready, 0);
    end
    @(posedge clk); #1;
    s_axis_valid = 1'b0; s_axis_last = 1'b0;
    m_axis_ready = 1'b1;
    wait_drain();

    // Reset during SEND aborts the frame and restarts the ramp.
    m_axis_ready = 1'b0;
    step_gain();
    send_word(24'h111111, 1'b0);
    send_word(24'h222222, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_axis_valid) break;
    end
    chk("pre_rst_valid", m_axis_valid, 1);
    resetn = 1'b0;
    #1;
    chk("midrst_m_valid", m_axis_valid, 0);
    chk("midrst_gain", gain_cur, 0);
    chk("midrst_m_data", m_axis_data, 0);
    exp_q.delete();
    gexp = 0;
    @(negedge clk); resetn = 1'b1;
    #1;
    chk("postrst_s_ready", s_axis_ready, 1);
    m_axis_ready = 1'b1;
    frame2(24'h100000, 24'hF00000, 24'h010000, 24'hFF0000);
    chk("postrst_gain", gain_cur, 1);

    repeat (5) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_multichannel_gain.md
# axis_multichannel_gain

AXI-Stream gain stage with N channels, placed between the I2S2 receive and transmit AXIS ports of the audio path. It accepts one frame per packet (one word per channel, `last` on the final word) and scales every sample by a per-frame current gain. The current gain slews toward a switch-selected target by a fixed step per frame, which removes zipper noise and pops on switch changes and on mute. Samples are multiplied one channel per cycle through a single shared multiplier.

## Interface
- `DATA_WIDTH`, 24: signed sample width.
- `NUM_CHANNELS`, 2: words per frame, ≥1.
- `GAIN_WIDTH`, 4: switch width. Gain is unsigned Q1.`GAIN_WIDTH`, range 0..2^`GAIN_WIDTH`.
- `RAMP_STEP`, 1: gain LSBs moved per accepted frame, ≥1.

Ports:
- `clk`  in  1: single clock.
- `resetn`  in  1: asynchronous, active-low reset.
- `sw`  in  `GAIN_WIDTH`: target gain select.
- `mute`  in  1: forces the target gain to 0.
- `s_axis_data`  in  `DATA_WIDTH`: input sample.
- `s_axis_valid`  in  1: input valid.
- `s_axis_ready`  out  1: input ready.
- `s_axis_last`  in  1: marks the final word of an input frame.
- `m_axis_data`  out  `DATA_WIDTH`: scaled output sample.
- `m_axis_valid`  out  1: output valid.
- `m_axis_ready`  in  1: output ready.
- `m_axis_last`  out  1: marks the final word of an output frame.
- `gain_cur`  out  `GAIN_WIDTH+1`: current applied gain.
- `frame_err`  out  1: 1-cycle pulse on a framing mismatch.

## Operation
- Target gain: `mute` → 0; otherwise `sw` all-ones → 2^`GAIN_WIDTH` (exact unity); otherwise `sw`.
- States:
  - RECV: `s_axis_ready`=1. Words are stored at channel index 0..N-1.
  - MULT: N cycles. Channel k is scaled in cycle k.
  - SEND: `m_axis_valid`=1. Channels are emitted 0..N-1, with `m_axis_last` on channel N-1.
- Transitions:
  - RECV→MULT on the handshake of the frame's final word.
  - MULT→SEND after N cycles.
  - SEND→RECV on the handshake with `m_axis_last`.
- Frame end is the first of two events: a handshake with `s_axis_last`=1, or the Nth word.
  - Early `last` (fewer than N words): `frame_err` pulses; missing channels are buffered as 0.
  - Nth word without `last`: `frame_err` pulses; the frame closes, and the next word starts a new frame.
- Gain slew: on the edge that enters MULT, `gain_cur` moves toward the target by `RAMP_STEP`, clamped at the target. That frame uses the updated value.
- `sw`/`mute` are sampled only at that edge. Changes mid-frame affect the next frame.
- Arithmetic:
  - The product is signed `DATA_WIDTH+GAIN_WIDTH+1` bits, with gain zero-extended.
  - Result = product >>> `GAIN_WIDTH` (floor), truncated to `DATA_WIDTH`.
  - Overflow cannot occur because gain ≤1.
  - Example: −1 × 8/16 → −1.

## Timing
- Reset values:
  - `s_axis_ready`=1; `m_axis_valid`=0; `m_axis_last`=0; `m_axis_data`=0.
  - `gain_cur`=0; `frame_err`=0; state=RECV; buffer cleared.
- Latency: `m_axis_valid` rises at the Nth edge after the edge accepting the frame's final word.
- Throughput: one frame per (N words in) + N + (N words out) cycles minimum. There is no overlap between receive and send.
- `s_axis_ready` is low from the closing handshake until the `m_axis_last` handshake completes.
- Under backpressure, `m_axis_data` and `m_axis_last` are held stable while `valid` is high and `ready` is low.
- `m_axis_valid` never drops without a handshake.
- Reset asserted in any state aborts immediately:
  - Outputs take their reset values asynchronously.
  - The partial frame is discarded.
  - After release, the gain ramps up from 0.

## Structure
- Shared package `axis_audio_pkg`:
  - State enum (RECV/MULT/SEND).
  - `GAIN_FRAC` localparam convention.
  - Target-mapping function (sw/mute → Q1.GW gain).
- Sub-module `gain_slew`: holds `gain_cur`, and computes the target and clamped step on an `update` strobe. It has its own `clk`/`resetn`.

## Test plan
Bench configuration for all scenarios: `DATA_WIDTH`=24, `NUM_CHANNELS`=2, `GAIN_WIDTH`=4, `RAMP_STEP`=1.

- Ramp up from reset: `sw`=4'hF, frame {0x100000, 0xF00000} → `gain_cur`=1 and output {0x010000, 0xFF0000}. `m_axis_valid` rises 2 edges after the last accept.
- Unity: after 16 frames with `sw`=F → `gain_cur`=16. Input {0x7FFFFF, 0x800000} is output unchanged.
- Mute ramp: at gain 16, assert `mute` → gain 15, 14, …, 0 on successive frames. Frame 16 outputs {0, 0}. Releasing `mute` ramps back up 1/frame.
- Early last: single word 0x200000 with `last`, gain 16 → `frame_err` pulses once. Output {0x200000, 0x000000}, with `m_axis_last` on the second word.
- Backpressure: `m_axis_ready`=0 for 10 cycles in SEND → `m_axis_valid`/data held constant and `s_axis_ready`=0. Offered slave words are not consumed.
- Reset mid-SEND: pulse `resetn` low → `m_axis_valid`=0 immediately and `gain_cur`=0. `s_axis_ready`=1 after release, and the next frame uses gain 1.
